bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (iterative double-dabble) for the DE0 four-digit 7-segment display path. Converts an unsigned binary value into DIGITS packed BCD nibbles plus a leading-zero blank mask. Each nibble feeds one per-digit 7-segment decoder directly downstream. Saturates to all-nines and flags overflow when the value exceeds the display range. Outputs hold their last result during a conversion, so the display never flickers.

---
 rtl/bin2bcd_seq_pkg.sv | 26 ++
 rtl/bin2bcd_seq_dd_add3.sv | 10 +
 rtl/bin2bcd_seq.sv | 153 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: FSM encodings,
// default digit count and the display-range helpers.
package bin2bcd_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  localparam int DIGITS_DEF = 4;

  // Largest value the display can show: 10^digits - 1.
  function automatic int unsigned bcd_max(input int digits);
    int unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

  // Width of a counter that must hold values up to n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_dd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next digit.
module dd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with saturation, overflow
// flag and a leading-zero blank mask for a multi-digit 7-segment display.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int                BCD_W     = 4 * DIGITS;
  localparam int                CNT_W     = count_width(BIN_W);
  localparam logic [31:0]       MAX_VAL   = 32'(bcd_max(DIGITS));
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  logic [1:0]        state_reg,    state_next;
  logic [CNT_W-1:0]  count_reg,    count_next;
  logic [BCD_W-1:0]  scratch_reg,  scratch_next;
  logic [BIN_W-1:0]  shreg_reg,    shreg_next;
  logic              ovf_pend_reg, ovf_pend_next;
  logic              busy_reg,     busy_next;
  logic              done_reg,     done_next;
  logic              valid_reg,    valid_next;
  logic              ovf_reg,      ovf_next;
  logic [BCD_W-1:0]  bcd_reg,      bcd_next;
  logic [DIGITS-1:0] blank_reg,    blank_next;

  logic [BCD_W-1:0]  scratch_adj;
  logic [DIGITS-1:0] blank_calc;
  logic              over_range;
  logic [BIN_W-1:0]  sat_val;

  // Saturated input keeps every scratch digit <= 9, so no carry ever leaves
  // the top digit.
  assign over_range = (32'(bin) > MAX_VAL);
  assign sat_val    = over_range ? MAX_VAL[BIN_W-1:0] : bin;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      dd_add3 u_add3 (
        .digit (scratch_reg[4*gi +: 4]),
        .adj   (scratch_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Digit i is a leading zero when it and every digit above it are zero;
  // the ones digit is always shown.
  assign blank_calc[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank_calc[gi] = (scratch_reg[BCD_W-1:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    scratch_next  = scratch_reg;
    shreg_next    = shreg_reg;
    ovf_pend_next = ovf_pend_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    valid_next    = valid_reg;
    ovf_next      = ovf_reg;
    bcd_next      = bcd_reg;
    blank_next    = blank_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          shreg_next    = sat_val;
          ovf_pend_next = over_range;
          scratch_next  = '0;
          count_next    = '0;
          busy_next     = 1'b1;
          state_next    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        scratch_next = {scratch_adj[BCD_W-2:0], shreg_reg[BIN_W-1]};
        shreg_next   = shreg_reg << 1;
        count_next   = count_reg + 1'b1;
        if (count_reg == LAST_ITER) begin
          state_next = ST_FIN;
        end
      end

      ST_FIN: begin
        bcd_next   = scratch_reg;
        blank_next = blank_calc;
        ovf_next   = ovf_pend_reg;
        valid_next = 1'b1;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      scratch_reg  <= '0;
      shreg_reg    <= '0;
      ovf_pend_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      bcd_reg      <= '0;
      blank_reg    <= BLANK_RST;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      scratch_reg  <= scratch_next;
      shreg_reg    <= shreg_next;
      ovf_pend_reg <= ovf_pend_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      valid_reg    <= valid_next;
      ovf_reg      <= ovf_next;
      bcd_reg      <= bcd_next;
      blank_reg    <= blank_next;
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign valid = valid_reg;
  assign ovf   = ovf_reg;
  assign bcd   = bcd_reg;
  assign blank = blank_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against an arithmetic
// reference (saturate, then divide/modulo into decimal digits).
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        valid;
  logic        ovf;
  logic [15:0] bcd;
  logic [3:0]  blank;

  int checks;
  int failures;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .valid (valid),
    .ovf   (ovf),
    .bcd   (bcd),
    .blank (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_sat(input int b);
    return (b > 9999) ? 9999 : b;
  endfunction

  function automatic logic [15:0] ref_bcd(input int b);
    int v;
    logic [15:0] r;
    v = ref_sat(b);
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_blank(input int b);
    int v;
    int p;
    logic [3:0] m;
    v = ref_sat(b);
    p = 1;
    m[0] = 1'b0;
    for (int i = 1; i < 4; i++) begin
      p = p * 10;
      m[i] = (v < p);
    end
    return m;
  endfunction

  // One conversion: start, wait (bounded) for done, check timing and result.
  task automatic convert(input int b, input bit inject);
    logic [15:0] hold;
    int n;
    int busy_n;
    hold = bcd;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'(b);
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin    = 14'($urandom_range(0, 16383));
    busy_n = busy ? 1 : 0;
    n = 0;
    while (!done && n < 100) begin
      if (inject && (n == 2 || n == 8)) begin
        start = 1'b1;
        bin   = 14'd42;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (!done) begin
        if (busy) busy_n++;
        check("bcd_hold", bcd, hold);
      end
    end
    check("latency", n, 15);
    check("busy_cycles", busy_n, 15);
    check("busy_at_done", busy, 0);
    check("bcd", bcd, ref_bcd(b));
    check("blank", blank, ref_blank(b));
    check("ovf", ovf, (b > 9999) ? 1 : 0);
    check("valid", valid, 1);
    $display("conv bin=%0d bcd=%04h blank=%04b ovf=%0b lat=%0d", b, bcd, blank, ovf, n);
  endtask

  initial begin
    int seen_done;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_blank", blank, 4'b1110);
    @(negedge clk);
    rst = 1'b0;

    convert(0, 1'b0);
    convert(1234, 1'b0);
    convert(9999, 1'b0);
    convert(10000, 1'b0);
    convert(16383, 1'b0);
    convert(7, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("no_queued_start", busy, 0);

    // Reset in the middle of a conversion discards everything.
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd500;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bcd", bcd, 16'h0000);
    check("abort_valid", valid, 0);
    check("abort_blank", blank, 4'b1110);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_idle_valid", valid, 0);
    convert(500, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      convert(int'($urandom_range(0, 16383)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
